// File: rtl/uart_rx_sequencer.sv
// ============================================================================
// Module   : uart_rx_sequencer
// Brief    : UART receive oversampling control FSM. Qualifies the start bit,
//            strobes the Rx datapath at bit centres and presents frame status.
//            Optional parity stage: define UART_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx_sequencer #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic baud_tick_i,
  input  logic rxd_sync_i,
  input  logic parity_error_i,
  input  logic rx_ack_i,
  output logic rx_shift_o,
  output logic parity_load_o,
  output logic check_stop_o,
  output logic rx_valid_o,
  output logic rx_perr_o,
  output logic rx_ferr_o,
  output logic rx_overrun_o,
  output logic busy_o
);

  localparam int C_OS_W = $clog2(OVERSAMPLE);
  localparam int C_BC_W = $clog2(DATA_BITS + 1);
  localparam logic [C_OS_W-1:0] C_OS_MID  = C_OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [C_OS_W-1:0] C_OS_LAST = C_OS_W'(OVERSAMPLE - 1);
  localparam logic [C_OS_W-1:0] C_OS_ONE  = C_OS_W'(1);
  localparam logic [C_BC_W-1:0] C_BC_LAST = C_BC_W'(DATA_BITS - 1);
  localparam logic [C_BC_W-1:0] C_BC_ONE  = C_BC_W'(1);

  localparam logic [2:0] C_IDLE      = 3'd0;
  localparam logic [2:0] C_START     = 3'd1;
  localparam logic [2:0] C_DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] C_PARITY    = 3'd3;
  localparam logic [2:0] C_PERR_WAIT = 3'd4;
`endif
  localparam logic [2:0] C_STOP      = 3'd5;
  localparam logic [2:0] C_DONE      = 3'd6;

  logic [2:0]        state_q, state_d;
  logic              armed_q, armed_d;
  logic [C_OS_W-1:0] os_cnt_q, os_cnt_d;
  logic [C_BC_W-1:0] bit_cnt_q, bit_cnt_d;
  logic              ferr_q, ferr_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_ferr_q, rx_ferr_d;
  logic              rx_overrun_q, rx_overrun_d;
`ifdef UART_RX_PARITY_EN
  logic              perr_q, perr_d;
  logic              rx_perr_q, rx_perr_d;
`endif

  logic w_bit_end;
  assign w_bit_end = baud_tick_i && (os_cnt_q == C_OS_LAST);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= C_IDLE;
      armed_q      <= 1'b0;
      os_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      ferr_q       <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_ferr_q    <= 1'b0;
      rx_overrun_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q       <= 1'b0;
      rx_perr_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      os_cnt_q     <= os_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      ferr_q       <= ferr_d;
      rx_valid_q   <= rx_valid_d;
      rx_ferr_q    <= rx_ferr_d;
      rx_overrun_q <= rx_overrun_d;
`ifdef UART_RX_PARITY_EN
      perr_q       <= perr_d;
      rx_perr_q    <= rx_perr_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q;
    os_cnt_d     = os_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    ferr_d       = ferr_q;
    rx_valid_d   = rx_valid_q;
    rx_ferr_d    = rx_ferr_q;
    rx_overrun_d = rx_overrun_q;
`ifdef UART_RX_PARITY_EN
    perr_d       = perr_q;
    rx_perr_d    = rx_perr_q;
`endif
    if (baud_tick_i) os_cnt_d = os_cnt_q + C_OS_ONE;
    if (rx_ack_i && rx_valid_q) begin
      rx_valid_d   = 1'b0;
      rx_ferr_d    = 1'b0;
      rx_overrun_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      rx_perr_d    = 1'b0;
`endif
    end
    case (state_q)
      C_IDLE: begin
        os_cnt_d  = '0;
        bit_cnt_d = '0;
        if (rxd_sync_i) armed_d = 1'b1;
        if (armed_q && baud_tick_i && !rxd_sync_i) state_d = C_START;
      end
      C_START: begin
        if (baud_tick_i && (os_cnt_q == C_OS_MID)) begin
          os_cnt_d  = '0;
          bit_cnt_d = '0;
          state_d   = rxd_sync_i ? C_IDLE : C_DATA;
        end
      end
      C_DATA: begin
        if (w_bit_end) begin
          os_cnt_d  = '0;
          bit_cnt_d = bit_cnt_q + C_BC_ONE;
          if (bit_cnt_q == C_BC_LAST) begin
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = C_PARITY;
`else
            state_d   = C_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      C_PARITY: begin
        if (w_bit_end) begin
          os_cnt_d = '0;
          state_d  = C_PERR_WAIT;
        end
      end
      // The wait clock belongs to the stop-bit period, so os_cnt carries into STOP.
      C_PERR_WAIT: begin
        perr_d  = parity_error_i;
        state_d = C_STOP;
      end
`endif
      C_STOP: begin
        if (w_bit_end) begin
          os_cnt_d = '0;
          ferr_d   = ~rxd_sync_i;
          state_d  = C_DONE;
        end
      end
      C_DONE: begin
        state_d    = C_IDLE;
        armed_d    = 1'b0;
        os_cnt_d   = '0;
        rx_valid_d = 1'b1;
        rx_ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
        rx_perr_d  = perr_q;
`endif
        if (rx_valid_q && !rx_ack_i) rx_overrun_d = 1'b1;
      end
      default: state_d = C_IDLE;
    endcase
  end

  always_comb begin
    rx_shift_o    = 1'b0;
    parity_load_o = 1'b0;
    check_stop_o  = 1'b0;
    busy_o        = (state_q != C_IDLE);
    case (state_q)
      C_DATA:   rx_shift_o    = w_bit_end;
`ifdef UART_RX_PARITY_EN
      C_PARITY: parity_load_o = w_bit_end;
`endif
      C_STOP:   check_stop_o  = w_bit_end;
      default:  ;
    endcase
  end

  assign rx_valid_o   = rx_valid_q;
  assign rx_ferr_o    = rx_ferr_q;
  assign rx_overrun_o = rx_overrun_q;
`ifdef UART_RX_PARITY_EN
  assign rx_perr_o    = rx_perr_q;
`else
  logic w_unused_parity;
  assign w_unused_parity = parity_error_i;
  assign rx_perr_o       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_sequencer.sv
// ============================================================================
// Module   : tb_uart_rx_sequencer
// Brief    : Scoreboard bench for uart_rx_sequencer; strobe timing, status,
//            overrun, glitch, break and reset cases at two baud_tick rates.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_sequencer;

  localparam int OS = 16;
  localparam int DB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif
  localparam int NBITS   = 1 + DB + PEN + 1;
  localparam int T_FIRST = OS / 2 + OS;
  localparam int T_PAR   = OS / 2 + OS * (DB + 1);
  localparam int T_STOP  = OS / 2 + OS * (DB + PEN + 1);

  logic clock, reset, baud_tick, rxd_sync, parity_error, rx_ack;
  logic rx_shift, parity_load, check_stop, rx_valid, rx_perr, rx_ferr, rx_overrun, busy;

  uart_rx_sequencer #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clock_i       (clock),
    .reset_i       (reset),
    .baud_tick_i   (baud_tick),
    .rxd_sync_i    (rxd_sync),
    .parity_error_i(parity_error),
    .rx_ack_i      (rx_ack),
    .rx_shift_o    (rx_shift),
    .parity_load_o (parity_load),
    .check_stop_o  (check_stop),
    .rx_valid_o    (rx_valid),
    .rx_perr_o     (rx_perr),
    .rx_ferr_o     (rx_ferr),
    .rx_overrun_o  (rx_overrun),
    .busy_o        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {logic perr; logic ferr;} exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int div      = 1;
  int rel_tick = 0;
  int nshift   = 0;
  bit rst_req = 0, ack_req = 0, ack_on_done = 0, inject_perr = 0;
  bit frame_active = 0, pload_prev = 0, cs_prev = 0;
  bit m_valid = 0, m_perr = 0, m_ferr = 0, m_ovr = 0;
  logic busy_at_tick = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, then advance the reference model.
  task automatic clk_cycle(input bit tick, input logic rxd_v);
    bit   done_cyc;
    exp_t e;
    @(negedge clock);
    done_cyc     = cs_prev;
    reset        = rst_req;
    baud_tick    = tick;
    rxd_sync     = rxd_v;
    rx_ack       = ack_req | (ack_on_done & done_cyc);
    parity_error = (PEN != 0) ? (pload_prev & inject_perr) : inject_perr;
    ack_req      = 1'b0;
    #1;
    if (reset) begin
      m_valid = 0; m_perr = 0; m_ferr = 0; m_ovr = 0;
      frame_active = 0; done_cyc = 0;
      check_val("rst_busy", busy, 0);
      check_val("rst_strobes", {rx_shift, parity_load, check_stop}, 0);
    end
    if (tick) busy_at_tick = busy;
    check_val("rx_valid", rx_valid, m_valid);
    check_val("rx_perr", rx_perr, m_perr);
    check_val("rx_ferr", rx_ferr, m_ferr);
    check_val("rx_overrun", rx_overrun, m_ovr);
    if (rx_shift | parity_load | check_stop) begin
      check_val("strobe_onehot", $countones({rx_shift, parity_load, check_stop}), 1);
      check_val("strobe_on_tick", baud_tick, 1);
      check_val("strobe_in_frame", frame_active, 1);
    end
    if (rx_shift) begin
      check_val("shift_time", rel_tick, T_FIRST + OS * nshift);
      nshift++;
    end
    if (parity_load) check_val("pload_time", rel_tick, T_PAR);
    if (check_stop) begin
      check_val("stop_time", rel_tick, T_STOP);
      check_val("shift_count", nshift, DB);
    end
    pload_prev = parity_load & ~reset;
    cs_prev    = check_stop & ~reset;
    if (!reset) begin
      if (done_cyc) begin
        e = '0;
        if (sb.size() == 0) check_val("sb_underflow", 0, 1);
        else e = sb.pop_front();
        if (rx_ack) m_ovr = 0;
        else if (m_valid) m_ovr = 1;
        m_valid = 1; m_perr = e.perr; m_ferr = e.ferr;
        frame_active = 0;
      end else if (rx_ack && m_valid) begin
        m_valid = 0; m_perr = 0; m_ferr = 0; m_ovr = 0;
      end
    end
  endtask

  task automatic tick_step(input logic rxd_v);
    clk_cycle(1'b1, rxd_v);
    rel_tick++;
    for (int i = 1; i < div; i++) clk_cycle(1'b0, rxd_v);
  endtask

  task automatic idle(input int n, input logic rxd_v);
    for (int i = 0; i < n; i++) tick_step(rxd_v);
  endtask

  task automatic ack_frame();
    ack_req = 1'b1;
    idle(2, 1'b1);
  endtask

  // rst_after > 0 aborts the frame with a reset pulse once that many shifts were seen.
  task automatic send_frame(input logic [8:0] data, input bit perr, input logic stop_bit,
                            input int rst_after);
    logic [NBITS-1:0] bits;
    bits = '0;
    for (int i = 0; i < DB; i++) bits[1 + i] = data[i];
    if (PEN != 0) bits[NBITS - 2] = ^data[DB-1:0];
    bits[NBITS - 1] = stop_bit;
    inject_perr = perr;
    if (rst_after == 0) sb.push_back('{perr: (PEN != 0) ? perr : 1'b0, ferr: ~stop_bit});
    rel_tick = 0; nshift = 0; frame_active = 1;
    for (int k = 0; k < NBITS * OS; k++) begin
      if (rst_after != 0 && nshift == rst_after) begin
        rst_req = 1'b1;
        clk_cycle(1'b0, bits[k / OS]);
        rst_req = 1'b0;
        break;
      end
      tick_step(bits[k / OS]);
    end
    inject_perr = 0;
  endtask

  initial begin
    reset = 1'b1; baud_tick = 1'b0; rxd_sync = 1'b1; parity_error = 1'b0; rx_ack = 1'b0;
    rst_req = 1'b1;
    clk_cycle(1'b0, 1'b1);
    clk_cycle(1'b0, 1'b1);
    rst_req = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      div = (pass == 0) ? 1 : 3;
      idle(4, 1'b1);
      // clean frame
      send_frame(9'h055, 0, 1'b1, 0);
      idle(4, 1'b1);
      ack_frame();
      // start glitch: low 4 ticks, back to IDLE at the centre tick
      frame_active = 0;
      idle(2, 1'b0);
      check_val("glitch_busy_early", busy_at_tick, 1);
      idle(2, 1'b0);
      idle(5, 1'b1);
      check_val("glitch_busy_at8", busy_at_tick, 1);
      idle(1, 1'b1);
      check_val("glitch_busy_after8", busy_at_tick, 0);
      idle(10, 1'b1);
      // framing error followed by a held-low break
      send_frame(9'h0A3, 0, 1'b0, 0);
      idle(40, 1'b0);
      check_val("break_no_rearm", busy_at_tick, 0);
      ack_req = 1'b1;
      idle(4, 1'b1);
      send_frame(9'h0F0, 0, 1'b1, 0);
      idle(4, 1'b1);
      ack_frame();
      // parity error does not abort the frame
      send_frame(9'h0C3, 1, 1'b1, 0);
      idle(4, 1'b1);
      ack_frame();
      // overrun, second frame's status shown
      send_frame(9'h012, 0, 1'b1, 0);
      idle(4, 1'b1);
      send_frame(9'h034, 1, 1'b0, 0);
      idle(4, 1'b1);
      check_val("overrun_set", rx_overrun, 1);
      ack_frame();
      // ack in the DONE clock: new frame wins, no overrun
      send_frame(9'h056, 0, 1'b1, 0);
      idle(4, 1'b1);
      ack_on_done = 1'b1;
      send_frame(9'h078, 0, 1'b0, 0);
      ack_on_done = 1'b0;
      idle(4, 1'b1);
      check_val("done_ack_no_ovr", rx_overrun, 0);
      check_val("done_ack_valid", rx_valid, 1);
      ack_frame();
      // stray ack while nothing is valid
      ack_frame();
      // reset mid-DATA with a frame still presented
      send_frame(9'h0AA, 0, 1'b1, 0);
      idle(4, 1'b1);
      send_frame(9'h05A, 0, 1'b1, 3);
      idle(6, 1'b1);
      send_frame(9'h0E7, 0, 1'b1, 0);
      idle(4, 1'b1);
      ack_frame();
    end
    check_val("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
